// File: rtl/dmem_lsu_ctrl.sv
// Load/store sequencer for a word-wide, synchronous-read data memory.
// Accepts one request at a time, decodes RISC-V funct3 for byte, half and
// word accesses, merges sub-word stores into the existing word and
// sign/zero-extends loads. Bad accesses are answered without touching memory.
module dmem_lsu_ctrl #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_mem_a;
  logic [31:0] r_mem_wd;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic        w_f3_ok;
  logic        w_misaligned;
  logic        w_out_of_range;
  logic        w_err;
  logic [4:0]  w_shift;
  logic [31:0] w_rd_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_mask;
  logic [31:0] w_ins;
  logic [31:0] w_merged;

  // Classify the incoming request; funct3 legality outranks alignment, which outranks range.
  always_comb begin
    w_f3_ok = 1'b0;
    if (req_we) begin
      w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      w_f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    end
    w_misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_out_of_range = ({2'b00, req_addr[31:2]} >= LP_WORDS);
    w_err          = !w_f3_ok || w_misaligned || w_out_of_range;
  end

  // Extract and extend the addressed lane of the returned memory word.
  always_comb begin
    w_shift      = {r_lane, 3'b000};
    w_rd_shifted = mem_rd >> w_shift;
    w_byte       = w_rd_shifted[7:0];
    w_half       = r_lane[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'h000000, w_byte};
      3'b101:  w_load = {16'h0000, w_half};
      default: w_load = mem_rd;
    endcase
  end

  // Replace the addressed byte/half of the returned word with the store data.
  always_comb begin
    if (r_funct3[1:0] == 2'b00) begin
      w_mask = 32'h0000_00FF << w_shift;
      w_ins  = {24'h000000, r_wdata[7:0]} << w_shift;
    end else begin
      w_mask = 32'h0000_FFFF << {r_lane[1], 4'b0000};
      w_ins  = {16'h0000, r_wdata} << {r_lane[1], 4'b0000};
    end
    w_merged = (mem_rd & ~w_mask) | (w_ins & w_mask);
  end

  // Request sequencer with registered handshake, response and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_a      <= 32'h0;
      r_mem_wd     <= 32'h0;
      r_we         <= 1'b0;
      r_funct3     <= 3'b000;
      r_lane       <= 2'b00;
      r_wdata      <= 16'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_lane      <= req_addr[1:0];
            r_wdata     <= req_wdata[15:0];
            r_mem_a     <= {req_addr[31:2], 2'b00};
            if (w_err) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
              r_state      <= S_RESP;
            end else if (req_we && (req_funct3 == 3'b010)) begin
              r_mem_wd <= req_wdata;
              r_state  <= S_WRITE;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          r_state <= r_we ? S_MERGE : S_LOAD;
        end
        S_LOAD: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load;
          r_state      <= S_RESP;
        end
        S_MERGE: begin
          r_mem_wd <= w_merged;
          r_state  <= S_WRITE;
        end
        S_WRITE: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Write enable is gated by reset so a reset cycle can never commit a store.
  assign mem_we     = (r_state == S_WRITE) && !rst;
  assign mem_a      = r_mem_a;
  assign mem_wd     = r_mem_wd;
  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl with a behavioural synchronous-read memory.
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int n_checks = 0;
  int n_fail   = 0;

  dmem_lsu_ctrl #(.MEM_WORDS(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous read, write on mem_we, plus a backdoor preload port.
  logic [31:0] mem [64];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = 6'd0;
  logic [31:0] bd_data = 32'h0;
  int          we_cnt = 0;
  logic [31:0] last_wa = 32'h0;
  logic [31:0] last_wd = 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
      we_cnt          <= we_cnt + 1;
      last_wa         <= mem_a;
      last_wd         <= mem_wd;
    end else if (bd_we) begin
      mem[bd_idx] <= bd_data;
    end
    mem_rd <= mem[mem_a[7:2]];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_idx  = idx;
    bd_data = data;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  // One request: returns accept-to-response latency (99 on timeout), response fields,
  // number of memory writes, last write address/data and whether req_ready was seen high while busy.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic err,
                        output logic [31:0] rd, output int nwe, output logic [31:0] lwa,
                        output logic [31:0] lwd, output logic rdy_busy);
    int w0;
    int k;
    w0       = we_cnt;
    rdy_busy = 1'b0;
    lat      = 99;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 10) begin
      if (req_ready) rdy_busy = 1'b1;
      @(negedge clk);
      k++;
    end
    if (req_ready) rdy_busy = 1'b1;
    if (resp_valid) lat = k;
    err = resp_err;
    rd  = resp_rdata;
    @(negedge clk);
    nwe = we_cnt - w0;
    lwa = last_wa;
    lwd = last_wd;
  endtask

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_lat;
    logic [1:0]  exp_nwe;
    logic [31:0] exp_wa;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t vecs [24];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          nwe;
    logic [31:0] lwa;
    logic [31:0] lwd;
    logic        rb;
    int          w0;
    logic        rdy_s [6];
    logic        rv_s  [6];
    logic        rdy_e [6];
    logic        rv_e  [6];

    //            we  f3    addr           wdata          err  rdata          lat  nwe  wa             wd
    vecs[0]  = '{1'b0, 3'd2, 32'h0000_0008, 32'h0,         1'b0, 32'hDEADBEEF, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 3'd2, 32'h0000_0008, 32'hDEAD80EF,  1'b0, 32'h0,        4'd2, 2'd1, 32'h0000_0008, 32'hDEAD80EF};
    vecs[2]  = '{1'b0, 3'd0, 32'h0000_0009, 32'h0,         1'b0, 32'hFFFFFF80, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[3]  = '{1'b0, 3'd4, 32'h0000_0009, 32'h0,         1'b0, 32'h00000080, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[4]  = '{1'b0, 3'd1, 32'h0000_000A, 32'h0,         1'b0, 32'hFFFFDEAD, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[5]  = '{1'b0, 3'd5, 32'h0000_000A, 32'h0,         1'b0, 32'h0000DEAD, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[6]  = '{1'b0, 3'd0, 32'h0000_0008, 32'h0,         1'b0, 32'hFFFFFFEF, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[7]  = '{1'b0, 3'd4, 32'h0000_000B, 32'h0,         1'b0, 32'h000000DE, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 3'd0, 32'h0000_0005, 32'h123456AA,  1'b0, 32'h0,        4'd4, 2'd1, 32'h0000_0004, 32'h1122AA44};
    vecs[9]  = '{1'b0, 3'd2, 32'h0000_0004, 32'h0,         1'b0, 32'h1122AA44, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[10] = '{1'b1, 3'd1, 32'h0000_0006, 32'h0000BEEF,  1'b0, 32'h0,        4'd4, 2'd1, 32'h0000_0004, 32'hBEEFAA44};
    vecs[11] = '{1'b1, 3'd0, 32'h0000_0007, 32'h000000FF,  1'b0, 32'h0,        4'd4, 2'd1, 32'h0000_0004, 32'hFFEFAA44};
    vecs[12] = '{1'b0, 3'd2, 32'h0000_0004, 32'h0,         1'b0, 32'hFFEFAA44, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[13] = '{1'b0, 3'd1, 32'h0000_0004, 32'h0,         1'b0, 32'hFFFFAA44, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[14] = '{1'b0, 3'd2, 32'h0000_00FC, 32'h0,         1'b0, 32'h0BADF00D, 4'd3, 2'd0, 32'h0,         32'h0};
    vecs[15] = '{1'b1, 3'd1, 32'h0000_0003, 32'h0000FFFF,  1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[16] = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[17] = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[18] = '{1'b1, 3'd4, 32'h0000_0000, 32'h12345678,  1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[19] = '{1'b0, 3'd1, 32'h0000_0001, 32'h0,         1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[20] = '{1'b0, 3'd2, 32'h0000_0002, 32'h0,         1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[21] = '{1'b1, 3'd2, 32'h0000_0100, 32'hCAFEF00D,  1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[22] = '{1'b0, 3'd6, 32'h0000_0000, 32'h0,         1'b1, 32'h0,        4'd1, 2'd0, 32'h0,         32'h0};
    vecs[23] = '{1'b0, 3'd2, 32'h0000_0000, 32'h0,         1'b0, 32'h01020304, 4'd3, 2'd0, 32'h0,         32'h0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state, sampled while reset is still applied and just after release.
    check("rst_req_ready",  {31'h0, req_ready},  32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_mem_we",     {31'h0, mem_we},     32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp_err",   {31'h0, resp_err},   32'h0);
    check("rst_resp_rdata", resp_rdata,          32'h0);
    check("rst_mem_a",      mem_a,               32'h0);
    check("rst_mem_wd",     mem_wd,              32'h0);

    poke(6'd0,  32'h01020304);
    poke(6'd1,  32'h11223344);
    poke(6'd2,  32'hDEADBEEF);
    poke(6'd5,  32'hAAAAAAAA);
    poke(6'd63, 32'h0BADF00D);

    for (int i = 0; i < 24; i++) begin
      do_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, err, rd, nwe, lwa, lwd, rb);
      $display("txn %0d: we=%0d f3=%0d addr=0x%08h wdata=0x%08h -> lat=%0d err=%0d rdata=0x%08h writes=%0d",
               i, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat, err, rd, nwe);
      check($sformatf("v%0d_latency", i), 32'(lat), {28'h0, vecs[i].exp_lat});
      check($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_writes", i), 32'(nwe), {30'h0, vecs[i].exp_nwe});
      check($sformatf("v%0d_ready_busy", i), {31'h0, rb}, 32'h0);
      if (vecs[i].exp_nwe != 2'd0) begin
        check($sformatf("v%0d_write_addr", i), lwa, vecs[i].exp_wa);
        check($sformatf("v%0d_write_data", i), lwd, vecs[i].exp_wd);
      end
    end

    // Reset arriving during WRITE must suppress the write and the response.
    w0 = we_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0014;
    req_wdata  = 32'h55555555;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    #1;
    check("rstw_mem_we", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    check("rstw_ready_after", {31'h0, req_ready}, 32'h1);
    check("rstw_no_resp", {31'h0, resp_valid}, 32'h0);
    @(negedge clk);
    check("rstw_no_resp2", {31'h0, resp_valid}, 32'h0);
    check("rstw_writes", 32'(we_cnt - w0), 32'h0);
    $display("reset-during-write: writes=%0d ready=%0d", we_cnt - w0, req_ready);
    do_txn(1'b0, 3'd2, 32'h0000_0014, 32'h0, lat, err, rd, nwe, lwa, lwd, rb);
    $display("txn rstw_readback: lat=%0d rdata=0x%08h", lat, rd);
    check("rstw_readback", rd, 32'hAAAAAAAA);

    // Two stores with req_valid held high: second accept only after the first RESP.
    rdy_e = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    rv_e  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    w0 = we_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h0000_0020;
    req_wdata  = 32'h0000_0001;
    for (int c = 0; c < 6; c++) begin
      rdy_s[c] = req_ready;
      rv_s[c]  = resp_valid;
      if (c == 1) begin
        req_addr  = 32'h0000_0024;
        req_wdata = 32'h0000_0002;
      end
      if (c == 5) req_valid = 1'b0;
      @(negedge clk);
    end
    for (int c = 0; c < 6; c++) begin
      $display("b2b cycle %0d: ready=%0d resp_valid=%0d", c, rdy_s[c], rv_s[c]);
      check($sformatf("b2b_ready_c%0d", c), {31'h0, rdy_s[c]}, {31'h0, rdy_e[c]});
      check($sformatf("b2b_resp_c%0d", c), {31'h0, rv_s[c]}, {31'h0, rv_e[c]});
    end
    check("b2b_writes", 32'(we_cnt - w0), 32'h2);
    do_txn(1'b0, 3'd2, 32'h0000_0020, 32'h0, lat, err, rd, nwe, lwa, lwd, rb);
    $display("txn b2b_read0: rdata=0x%08h", rd);
    check("b2b_word8", rd, 32'h0000_0001);
    do_txn(1'b0, 3'd2, 32'h0000_0024, 32'h0, lat, err, rd, nwe, lwa, lwd, rb);
    $display("txn b2b_read1: rdata=0x%08h", rd);
    check("b2b_word9", rd, 32'h0000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Load/store controller that sequences the word-wide, synchronous-read data memory on behalf of the CPU core. It accepts one request at a time through a valid/ready handshake and decodes RISC-V funct3 for LB/LH/LW/LBU/LHU/SB/SH/SW. It performs read-modify-write for sub-word stores and sign- or zero-extends loads. It flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.

Parameters:
MEM_WORDS, 64, number of 32-bit words in the data memory; legal word index range is 0..MEM_WORDS-1.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_funct3  input  3  RISC-V access size/sign code
req_addr  input  32  byte address
req_wdata  input  32  store data; low byte/half used for SB/SH
resp_valid  output  1  one-cycle completion pulse
resp_err  output  1  qualifies resp_valid; access rejected
resp_rdata  output  32  formatted load data; 0 for stores and errors
mem_we  output  1  memory write enable
mem_a  output  32  memory byte address, always word-aligned
mem_wd  output  32  memory write data
mem_rd  input  32  memory read data; valid the cycle after a non-WE cycle

Behaviour:
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_we=0; mem_a=0; mem_wd=0. All capture registers are cleared.
- Handshake: accept occurs when req_valid && req_ready. The request fields are captured at that edge, and req_ready drops the next cycle. No response backpressure: resp_valid is a single-cycle pulse. resp_rdata and resp_err hold until the next response.
- Address mapping: mem_a = {addr[31:2],2'b00} from the captured register. Little-endian byte lanes: byte lane = addr[1:0], half lane = addr[1].
- Error check at accept, in priority order:
  - illegal funct3: loads allow 000/001/010/100/101; stores allow 000/001/010;
  - misaligned: half with addr[0]=1, or word with addr[1:0]!=0;
  - out of range: addr[31:2] >= MEM_WORDS.
  - Error path is IDLE -> RESP. resp_err=1, resp_rdata=0, mem_we never asserted.
- FSM states: IDLE, READ, LOAD, MERGE, WRITE, RESP.
  - Load: IDLE -> READ -> LOAD -> RESP.
    - READ drives mem_a with mem_we=0.
    - LOAD formats mem_rd into resp_rdata: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
  - SW: IDLE -> WRITE -> RESP. WRITE drives mem_we=1 and mem_wd=wdata.
  - SB/SH: IDLE -> READ -> MERGE -> WRITE -> RESP.
    - MERGE registers mem_rd with the selected lane(s) replaced by wdata[7:0] or wdata[15:0].
    - All other bytes are preserved.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- Latency, counted from the accept edge to the resp_valid cycle:
  - error: 1 cycle;
  - SW: 2 cycles;
  - load: 3 cycles;
  - SB/SH: 4 cycles.
- Throughput: the next request can be accepted no earlier than the cycle after RESP.
- mem_we is high only in WRITE, exactly one cycle per store. mem_we = (state==WRITE) && !rst, so no write commits in a reset cycle.
- Reset mid-operation: the in-flight request is dropped with no response. Memory is untouched unless WRITE already completed before rst.
- req_* inputs are ignored outside IDLE.

Test Plan:
- Reset, then LW addr 0x8 with memory word 2 = 0xDEADBEEF -> resp_valid exactly 3 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0, mem_we never high.
- LB addr 0x9 and LBU addr 0x9 on word 0xDEAD80EF -> LB gives 0xFFFFFF80, LBU gives 0x00000080. LH addr 0xA gives 0xFFFFDEAD.
- SB addr 0x5, wdata 0x123456AA, word 1 = 0x11223344 -> exactly one mem_we cycle with mem_a=0x4 and mem_wd=0x1122AA44. resp_valid 4 cycles after accept; a later LW 0x4 returns 0x1122AA44.
- SH addr 0x3 (misaligned); LW with addr[31:2]=MEM_WORDS; load with funct3=011; SB with funct3=100 -> each gives resp_valid+resp_err 1 cycle after accept, resp_rdata=0, no mem_we.
- SW accepted, then rst asserted during WRITE -> mem_we=0 that cycle, memory word unchanged, no resp_valid. IDLE with req_ready=1 the cycle after rst deasserts.
- req_valid held high across two back-to-back SW requests -> second accepted only in the cycle after the first RESP; req_ready low in all non-IDLE cycles.
